// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: owns the UART baud-rate divisor. Accepts divisor updates,
// parks the UART (uart_hold) until TX/RX are idle, then loads the new divisor
// and pulses brg_reset so the baud-rate generator restarts cleanly.
// Optional autobaud (define UART_AUTOBAUD_EN): measures the start bit of a
// received 0x55 and derives the divisor from it (16x oversampling).
`timescale 1ns/1ps

module uart_baud_ctrl #(
  parameter int DVSR_W       = 11,
  parameter int DEFAULT_DVSR = 325,
  parameter int MIN_DVSR     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef UART_AUTOBAUD_EN
  input  logic              ab_start,
  input  logic              rx,
`endif
  input  logic              cfg_valid,
  input  logic [DVSR_W-1:0] cfg_dvsr,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic              uart_busy,
  output logic              uart_hold,
  output logic [DVSR_W-1:0] dvsr,
  output logic              brg_reset
);

  localparam logic [DVSR_W-1:0] DEFAULT_V = DVSR_W'(DEFAULT_DVSR);
  localparam logic [DVSR_W-1:0] MIN_V     = DVSR_W'(MIN_DVSR);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    APPLY,
    DONE
`ifdef UART_AUTOBAUD_EN
    ,
    AB_WAIT,
    AB_MEAS
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [DVSR_W-1:0] pend_q;
  logic [DVSR_W-1:0] dvsr_q;
  logic [DVSR_W-1:0] apply_val;
  logic              err_q, err_d;
  logic              accept;

`ifdef UART_AUTOBAUD_EN
  localparam int                CNT_W    = DVSR_W + 4;
  localparam logic [DVSR_W-1:0] MIN_MEAS = DVSR_W'(MIN_DVSR + 1);

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic             rx_fall, rx_rise;
  logic [CNT_W-1:0] cnt_q;
  logic [DVSR_W-1:0] meas_div;

  // Two-flop synchronizer for the asynchronous rx line, plus a delayed copy
  // for edge detection. Reset to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_fall  = rx_prev_q & ~rx_s2_q;
  assign rx_rise  = ~rx_prev_q & rx_s2_q;
  // Clocks per bit divided by 16; the divisor is this minus one.
  assign meas_div = cnt_q[CNT_W-1:4];

  // Start-bit length counter: starts at 1 on the falling edge, counts every
  // clock rx stays low, saturates at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (state_q == AB_WAIT && rx_fall) begin
      cnt_q <= CNT_W'(1);
    end else if (state_q == AB_MEAS && !rx_s2_q && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`endif

  // State, divisor, pending value and error pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= DEFAULT_V;
      dvsr_q  <= DEFAULT_V;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) pend_q <= cfg_dvsr;
      // The divisor is loaded only on entry to APPLY, so it is never seen to
      // change in any other state.
      if (state_d == APPLY) dvsr_q <= apply_val;
    end
  end

  // Next-state logic, request acceptance and error detection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    apply_val = pend_q;
    unique case (state_q)
      IDLE: begin
        // A config request takes priority over an autobaud start.
        if (cfg_valid) begin
          if (cfg_dvsr >= MIN_V) begin
            accept  = 1'b1;
            state_d = DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef UART_AUTOBAUD_EN
        else if (ab_start) begin
          state_d = AB_WAIT;
        end
`endif
      end
      DRAIN: if (!uart_busy) state_d = APPLY;
      APPLY: state_d = DONE;
      DONE:  state_d = IDLE;
`ifdef UART_AUTOBAUD_EN
      AB_WAIT: if (rx_fall) state_d = AB_MEAS;
      AB_MEAS: begin
        if (rx_rise) begin
          if (cnt_q == '1 || meas_div < MIN_MEAS) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            // The UART was already parked while waiting, so skip DRAIN.
            apply_val = meas_div - DVSR_W'(1);
            state_d   = APPLY;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: everything comes from registered state.
  always_comb begin
    cfg_ready = (state_q == IDLE);
    uart_hold = (state_q != IDLE);
    brg_reset = (state_q == APPLY);
    cfg_done  = (state_q == DONE);
    cfg_err   = err_q;
    dvsr      = dvsr_q;
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Testbench for uart_baud_ctrl: directed vectors; done/err/brg_reset pulses
// are checked by a scoreboard monitor against expectations queued by the
// stimulus. Autobaud vectors run only when UART_AUTOBAUD_EN is defined.
`timescale 1ns/1ps

module tb_uart_baud_ctrl;

  localparam int DVSR_W = 11;

  localparam logic [2:0] EV_APPLY = 3'b100;
  localparam logic [2:0] EV_DONE  = 3'b010;
  localparam logic [2:0] EV_ERR   = 3'b001;

  typedef struct packed {
    logic [2:0]        kind;
    logic [DVSR_W-1:0] dvsr;
  } exp_t;

  logic              clk;
  logic              reset_n;
  logic              cfg_valid;
  logic [DVSR_W-1:0] cfg_dvsr;
  logic              cfg_ready;
  logic              cfg_done;
  logic              cfg_err;
  logic              uart_busy;
  logic              uart_hold;
  logic [DVSR_W-1:0] dvsr;
  logic              brg_reset;
`ifdef UART_AUTOBAUD_EN
  logic              ab_start;
  logic              rx;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  uart_baud_ctrl #(
    .DVSR_W(DVSR_W), .DEFAULT_DVSR(325), .MIN_DVSR(2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef UART_AUTOBAUD_EN
    .ab_start  (ab_start),
    .rx        (rx),
`endif
    .cfg_valid (cfg_valid),
    .cfg_dvsr  (cfg_dvsr),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .uart_busy (uart_busy),
    .uart_hold (uart_hold),
    .dvsr      (dvsr),
    .brg_reset (brg_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [DVSR_W-1:0] v);
    exp_t e;
    e.kind = kind;
    e.dvsr = v;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && (brg_reset || cfg_done || cfg_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({brg_reset, cfg_done, cfg_err}), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({brg_reset, cfg_done, cfg_err}), 32'(e.kind));
        check("pulse_dvsr", 32'(dvsr), 32'(e.dvsr));
      end
    end
  end

  // Watchdog: the bench must never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_dvsr  = '0;
    uart_busy = 1'b0;
`ifdef UART_AUTOBAUD_EN
    ab_start  = 1'b0;
    rx        = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: reset state
    @(negedge clk);
    check("rst_dvsr",  32'(dvsr), 32'(325));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    check("rst_hold",  32'(uart_hold), 32'(0));
    check("rst_brg",   32'(brg_reset), 32'(0));
    check("rst_done",  32'(cfg_done), 32'(0));
    check("rst_err",   32'(cfg_err), 32'(0));

    // 2: update to 26 with UART idle; exact latency
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_dvsr = 11'd26;
    expect_ev(EV_APPLY, 11'd26);
    expect_ev(EV_DONE, 11'd26);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("c1_ready", 32'(cfg_ready), 32'(0));
    check("c1_hold",  32'(uart_hold), 32'(1));
    check("c1_dvsr",  32'(dvsr), 32'(325));
    @(negedge clk);
    check("c2_dvsr",  32'(dvsr), 32'(26));
    check("c2_brg",   32'(brg_reset), 32'(1));
    @(negedge clk);
    check("c3_done",  32'(cfg_done), 32'(1));
    check("c3_brg",   32'(brg_reset), 32'(0));
    check("c3_hold",  32'(uart_hold), 32'(1));
    @(negedge clk);
    check("c4_ready", 32'(cfg_ready), 32'(1));
    check("c4_hold",  32'(uart_hold), 32'(0));

    // 4a: divisor below minimum is rejected, dvsr unchanged
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_dvsr = 11'd1;
    expect_ev(EV_ERR, 11'd26);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(cfg_err), 32'(1));
    check("err_ready", 32'(cfg_ready), 32'(1));
    check("err_hold",  32'(uart_hold), 32'(0));
    @(negedge clk);
    check("err_clear", 32'(cfg_err), 32'(0));
    check("err_dvsr",  32'(dvsr), 32'(26));

    // back to default divisor
    @(posedge clk); #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst2_dvsr", 32'(dvsr), 32'(325));

    // 3 + 4b: UART busy holds the update; requests during DRAIN ignored
    @(posedge clk); #1;
    uart_busy = 1'b1; cfg_valid = 1'b1; cfg_dvsr = 11'd52;
    expect_ev(EV_APPLY, 11'd52);
    expect_ev(EV_DONE, 11'd52);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cfg_valid = (i >= 10 && i < 13);
      cfg_dvsr  = (i >= 10 && i < 13) ? 11'd77 : 11'd52;
      @(negedge clk);
      check("drain_hold",  32'(uart_hold), 32'(1));
      check("drain_ready", 32'(cfg_ready), 32'(0));
      check("drain_dvsr",  32'(dvsr), 32'(325));
    end
    @(posedge clk); #1;
    uart_busy = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    check("drop_dvsr0", 32'(dvsr), 32'(325));
    @(negedge clk);
    check("drop_dvsr1", 32'(dvsr), 32'(52));
    check("drop_brg",   32'(brg_reset), 32'(1));
    repeat (3) @(negedge clk);
    check("drop_ready", 32'(cfg_ready), 32'(1));
    check("drop_final", 32'(dvsr), 32'(52));

    // 5: reset during DRAIN aborts and discards the pending value
    @(posedge clk); #1;
    uart_busy = 1'b1; cfg_valid = 1'b1; cfg_dvsr = 11'd100;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("abort_hold_pre", 32'(uart_hold), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("abort_dvsr",  32'(dvsr), 32'(325));
    check("abort_ready", 32'(cfg_ready), 32'(1));
    check("abort_hold",  32'(uart_hold), 32'(0));
    check("abort_brg",   32'(brg_reset), 32'(0));
    check("abort_done",  32'(cfg_done), 32'(0));
    check("abort_err",   32'(cfg_err), 32'(0));
    @(posedge clk); #1;
    reset_n = 1'b1; uart_busy = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_keep_dvsr",  32'(dvsr), 32'(325));
    check("abort_keep_ready", 32'(cfg_ready), 32'(1));

    // boundary: MIN_DVSR itself is accepted
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_dvsr = 11'd2;
    expect_ev(EV_APPLY, 11'd2);
    expect_ev(EV_DONE, 11'd2);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("min_dvsr",  32'(dvsr), 32'(2));
    check("min_ready", 32'(cfg_ready), 32'(1));

`ifdef UART_AUTOBAUD_EN
    // 6a: 5208-clock start bit -> (5208>>4)-1 = 324
    @(posedge clk); #1 ab_start = 1'b1;
    @(posedge clk); #1 ab_start = 1'b0;
    @(negedge clk);
    check("ab_wait_hold", 32'(uart_hold), 32'(1));
    expect_ev(EV_APPLY, 11'd324);
    expect_ev(EV_DONE, 11'd324);
    @(posedge clk); #1 rx = 1'b0;
    repeat (5208) @(posedge clk);
    #1 rx = 1'b1;
    repeat (10) @(negedge clk);
    check("ab_dvsr",  32'(dvsr), 32'(324));
    check("ab_ready", 32'(cfg_ready), 32'(1));

    // 6b: 40-clock start bit -> (40>>4)-1 = 1 < MIN_DVSR -> error
    @(posedge clk); #1 ab_start = 1'b1;
    @(posedge clk); #1 ab_start = 1'b0;
    expect_ev(EV_ERR, 11'd324);
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk);
    #1 rx = 1'b1;
    repeat (10) @(negedge clk);
    check("ab_fail_dvsr",  32'(dvsr), 32'(324));
    check("ab_fail_ready", 32'(cfg_ready), 32'(1));
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
